// File: rtl/text_loader_if.sv
// Loader-side bundle: byte stream from uart_rx, single-cycle write port toward text_mem, loader status.
// ADDR_WIDTH may be predefined by the build; otherwise text_mem is 8192 words (13-bit index).
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 13
`endif

interface text_loader_if #(
    parameter int ADDR_W = `ADDR_WIDTH
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr;
    logic [17:0]       mem_wr_data;
    logic              cpu_rst;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output rx_data, rx_valid,
        input  mem_addr, mem_wr, mem_wr_data, cpu_rst, busy, done, err
    );

    modport slave (
        input  rx_data, rx_valid,
        output mem_addr, mem_wr, mem_wr_data, cpu_rst, busy, done, err
    );
endinterface

// File: rtl/text_loader.sv
// Boot loader: unpacks an A5-framed byte stream into 18-bit text_mem words and holds the CPU in reset until done.
// Define TEXT_LOADER_CHECKSUM_EN to require a trailing two's-complement checksum byte before DONE.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 13
`endif

module text_loader #(
    parameter int ADDR_W  = `ADDR_WIDTH,
    parameter int DEPTH   = 8192,
    parameter int TIMEOUT = 1000000
) (
    input  logic         clk,
    input  logic         rst,
    text_loader_if.slave bus
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_HDR0  = 4'd1;
    localparam logic [3:0] S_HDR1  = 4'd2;
    localparam logic [3:0] S_DATA0 = 4'd3;
    localparam logic [3:0] S_DATA1 = 4'd4;
    localparam logic [3:0] S_DATA2 = 4'd5;
    localparam logic [3:0] S_DONE  = 4'd6;
    localparam logic [3:0] S_ERR   = 4'd7;
`ifdef TEXT_LOADER_CHECKSUM_EN
    localparam logic [3:0] S_CSUM  = 4'd8;
    localparam logic [3:0] S_FINAL = S_CSUM;
`else
    localparam logic [3:0] S_FINAL = S_DONE;
`endif

    localparam int          TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [16:0] DEPTH_LIM  = 17'(DEPTH);

    logic [3:0]        state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_q, wr_d;
    logic [17:0]       wr_data_q, wr_data_d;
    logic [7:0]        b0_q, b0_d;
    logic [7:0]        b1_q, b1_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              in_frame;
    logic              last_word;
    logic [15:0]       cnt_hdr;

    always_comb begin
        in_frame = (state_q == S_HDR0) || (state_q == S_HDR1) || (state_q == S_DATA0) ||
                   (state_q == S_DATA1) || (state_q == S_DATA2);
`ifdef TEXT_LOADER_CHECKSUM_EN
        in_frame = in_frame || (state_q == S_CSUM);
`endif
    end

    assign last_word = ((17'(idx_q) + 17'd1) == {1'b0, cnt_q});
    assign cnt_hdr   = {bus.rx_data, cnt_q[7:0]};

`ifdef TEXT_LOADER_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;

    // Running sum covers every byte after the 0xA5 marker up to the last B2.
    always_comb begin
        sum_d = sum_q;
        if (bus.rx_valid) begin
            if (((state_q == S_IDLE) || (state_q == S_ERR)) && (bus.rx_data == 8'hA5)) begin
                sum_d = 8'h00;
            end else if ((state_q == S_HDR0) || (state_q == S_HDR1) || (state_q == S_DATA0) ||
                         (state_q == S_DATA1) || (state_q == S_DATA2)) begin
                sum_d = sum_q + bus.rx_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= 8'h00;
        end else begin
            sum_q <= sum_d;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        addr_d    = addr_q;
        wr_d      = 1'b0;
        wr_data_d = wr_data_q;
        b0_d      = b0_q;
        b1_d      = b1_q;
        timer_d   = '0;

        // A byte arriving on the timeout cycle takes priority and restarts the idle count.
        if (in_frame && !bus.rx_valid) begin
            if (timer_q == TIMER_LAST) begin
                state_d = S_ERR;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end

        if (bus.rx_valid) begin
            case (state_q)
                S_IDLE, S_ERR: begin
                    if (bus.rx_data == 8'hA5) begin
                        state_d = S_HDR0;
                        idx_d   = '0;
                        addr_d  = '0;
                    end
                end
                S_HDR0: begin
                    cnt_d[7:0] = bus.rx_data;
                    state_d    = S_HDR1;
                end
                S_HDR1: begin
                    cnt_d[15:8] = bus.rx_data;
                    if (cnt_hdr == 16'd0) begin
                        state_d = S_FINAL;
                    end else if ({1'b0, cnt_hdr} > DEPTH_LIM) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA0;
                    end
                end
                S_DATA0: begin
                    b0_d    = bus.rx_data;
                    state_d = S_DATA1;
                end
                S_DATA1: begin
                    b1_d    = bus.rx_data;
                    state_d = S_DATA2;
                end
                S_DATA2: begin
                    if (bus.rx_data[7:2] != 6'd0) begin
                        state_d = S_ERR;
                    end else begin
                        wr_d      = 1'b1;
                        wr_data_d = {bus.rx_data[1:0], b1_q, b0_q};
                        addr_d    = idx_q;
                        idx_d     = idx_q + 1'b1;
                        state_d   = last_word ? S_FINAL : S_DATA0;
                    end
                end
`ifdef TEXT_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    state_d = ((sum_q + bus.rx_data) == 8'h00) ? S_DONE : S_ERR;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 16'd0;
            idx_q     <= '0;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            wr_data_q <= 18'd0;
            b0_q      <= 8'd0;
            b1_q      <= 8'd0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            addr_q    <= addr_d;
            wr_q      <= wr_d;
            wr_data_q <= wr_data_d;
            b0_q      <= b0_d;
            b1_q      <= b1_d;
            timer_q   <= timer_d;
        end
    end

    assign bus.mem_addr    = addr_q;
    assign bus.mem_wr      = wr_q;
    assign bus.mem_wr_data = wr_data_q;
    assign bus.cpu_rst     = (state_q != S_DONE);
    assign bus.busy        = in_frame;
    assign bus.done        = (state_q == S_DONE);
    assign bus.err         = (state_q == S_ERR);

endmodule

// File: tb/tb_text_loader.sv
// Randomized frame bench for text_loader: a frame-level parser predicts writes and final status.
// Honors TEXT_LOADER_CHECKSUM_EN by appending/expecting the trailing checksum byte.
module tb_text_loader;

    localparam int ADDR_W     = 13;
    localparam int DEPTH      = 8192;
    localparam int TB_TIMEOUT = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int errors = 0;
    int checks = 0;

    byte unsigned frameQ[$];
    bit           expWrFlag[$];
    logic [30:0]  expWrQ[$];
    logic [30:0]  obsQ[$];
    bit           expErr;
    bit           expDone;
    int           expCnt;
    logic         prevWr = 1'b0;

    text_loader_if #(.ADDR_W(ADDR_W)) bus ();

    text_loader #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .TIMEOUT(TB_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Collect every write, and insist mem_wr never stays high two cycles running.
    always @(negedge clk) begin
        if (prevWr) checkOutput("wr_single", 32'(bus.mem_wr), 32'd0);
        if (bus.mem_wr === 1'b1) obsQ.push_back({bus.mem_addr, bus.mem_wr_data});
        prevWr = bus.mem_wr;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input byte unsigned b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic doReset();
        rst          = 1'b1;
        bus.rx_valid = 1'b0;
        idle(2);
        rst = 1'b0;
        idle(1);
    endtask

    task automatic checkResetValues();
        checkOutput("rst_addr", 32'(bus.mem_addr), 32'd0);
        checkOutput("rst_wr", 32'(bus.mem_wr), 32'd0);
        checkOutput("rst_wdata", 32'(bus.mem_wr_data), 32'd0);
        checkOutput("rst_cpu_rst", 32'(bus.cpu_rst), 32'd1);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_done", 32'(bus.done), 32'd0);
        checkOutput("rst_err", 32'(bus.err), 32'd0);
    endtask

    task automatic appendChecksum();
        int s = 0;
        for (int i = 1; i < frameQ.size(); i++) s += frameQ[i];
        frameQ.push_back(8'((256 - (s % 256)) % 256));
    endtask

    // Parse the whole frame the way a software loader would: header, word list, optional checksum.
    task automatic modelFrame();
        int           s;
        int           base;
        byte unsigned b2;
        expWrQ.delete();
        expWrFlag.delete();
        expErr  = 1'b0;
        expDone = 1'b0;
        foreach (frameQ[i]) expWrFlag.push_back(1'b0);
        expCnt = int'(frameQ[1]) + 256 * int'(frameQ[2]);
        s      = int'(frameQ[1]) + int'(frameQ[2]);
        if (expCnt > DEPTH) begin
            expErr = 1'b1;
            return;
        end
        for (int w = 0; w < expCnt; w++) begin
            base = 3 + 3 * w;
            b2   = frameQ[base + 2];
            if (b2 > 8'd3) begin
                expErr = 1'b1;
                return;
            end
            expWrQ.push_back({13'(w), b2[1:0], frameQ[base + 1], frameQ[base]});
            expWrFlag[base + 2] = 1'b1;
            s += int'(frameQ[base]) + int'(frameQ[base + 1]) + int'(b2);
        end
`ifdef TEXT_LOADER_CHECKSUM_EN
        if (((s + int'(frameQ[3 + 3 * expCnt])) % 256) != 0) begin
            expErr = 1'b1;
            return;
        end
`endif
        expDone = 1'b1;
    endtask

    task automatic buildRandomFrame();
        int  cnt;
        bit  bad = 1'b0;
        byte unsigned b2;
        frameQ.delete();
        cnt = ($urandom_range(0, 9) == 0) ? DEPTH + 1 + $urandom_range(0, 300) : $urandom_range(0, 5);
        frameQ.push_back(8'hA5);
        frameQ.push_back(8'(cnt));
        frameQ.push_back(8'(cnt >> 8));
        if (cnt > DEPTH) return;
        for (int w = 0; w < cnt && !bad; w++) begin
            frameQ.push_back(8'($urandom));
            frameQ.push_back(8'($urandom));
            if ($urandom_range(0, 11) == 0) begin
                b2  = 8'($urandom_range(4, 255));
                bad = 1'b1;
            end else begin
                b2 = 8'($urandom_range(0, 3));
            end
            frameQ.push_back(b2);
        end
`ifdef TEXT_LOADER_CHECKSUM_EN
        if (!bad) begin
            appendChecksum();
            if ($urandom_range(0, 3) == 0) frameQ[frameQ.size() - 1] ^= 8'(1 << $urandom_range(0, 7));
        end
`endif
    endtask

    task automatic runFrame(input bit withReset);
        if (withReset) doReset();
        modelFrame();
        obsQ.delete();
        for (int i = 0; i < frameQ.size(); i++) begin
            applyStimulus(frameQ[i]);
            checkOutput("wr_latency", 32'(bus.mem_wr), 32'(expWrFlag[i]));
            if (i == 0) checkOutput("busy_hdr", 32'(bus.busy), 32'd1);
            idle($urandom_range(1, 3));
        end
        idle(2);
        checkOutput("frame_err", 32'(bus.err), 32'(expErr));
        checkOutput("frame_done", 32'(bus.done), 32'(expDone));
        checkOutput("frame_busy", 32'(bus.busy), 32'd0);
        checkOutput("frame_cpu_rst", 32'(bus.cpu_rst), 32'(!expDone));
        checkOutput("write_count", 32'(obsQ.size()), 32'(expWrQ.size()));
        for (int i = 0; i < expWrQ.size() && i < obsQ.size(); i++)
            checkOutput("write_word", 32'(obsQ[i]), 32'(expWrQ[i]));
        if (expDone)
            checkOutput("addr_hold", 32'(bus.mem_addr), (expCnt > 0) ? 32'(expCnt - 1) : 32'd0);
    endtask

    task automatic pushBytes(input byte unsigned a, input byte unsigned b, input byte unsigned c);
        frameQ.push_back(a);
        frameQ.push_back(b);
        frameQ.push_back(c);
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        @(negedge clk);
        doReset();
        checkResetValues();

        // Two-word image from the datasheet example.
        frameQ.delete();
        pushBytes(8'hA5, 8'h02, 8'h00);
        pushBytes(8'h34, 8'h12, 8'h03);
        pushBytes(8'hFF, 8'hFF, 8'h00);
`ifdef TEXT_LOADER_CHECKSUM_EN
        appendChecksum();
`endif
        runFrame(1'b0);
        checkOutput("ex_word0", 32'(obsQ.size() > 0 ? obsQ[0] : 31'h7FFFFFFF), {1'b0, 13'd0, 18'h31234});
        checkOutput("ex_word1", 32'(obsQ.size() > 1 ? obsQ[1] : 31'h7FFFFFFF), {1'b0, 13'd1, 18'h0FFFF});
        checkOutput("ex_done", 32'(bus.done), 32'd1);

        // Bytes after DONE are ignored, even a new frame marker.
        obsQ.delete();
        applyStimulus(8'hA5); idle(2);
        applyStimulus(8'h01); idle(2);
        applyStimulus(8'h00); idle(2);
        checkOutput("done_sticky", 32'(bus.done), 32'd1);
        checkOutput("done_busy", 32'(bus.busy), 32'd0);
        checkOutput("done_no_wr", 32'(obsQ.size()), 32'd0);

        // Empty image.
        frameQ.delete();
        pushBytes(8'hA5, 8'h00, 8'h00);
`ifdef TEXT_LOADER_CHECKSUM_EN
        appendChecksum();
`endif
        runFrame(1'b1);

        // Bad B2 aborts without a write; a fresh frame recovers from ERR.
        frameQ.delete();
        pushBytes(8'hA5, 8'h01, 8'h00);
        pushBytes(8'h34, 8'h12, 8'h04);
        runFrame(1'b1);
        checkOutput("bad_b2_err", 32'(bus.err), 32'd1);
        frameQ.delete();
        pushBytes(8'hA5, 8'h01, 8'h00);
        pushBytes(8'h01, 8'h00, 8'h00);
`ifdef TEXT_LOADER_CHECKSUM_EN
        appendChecksum();
`endif
        runFrame(1'b0);
        checkOutput("recover_word", 32'(obsQ.size() > 0 ? obsQ[0] : 31'h7FFFFFFF), {1'b0, 13'd0, 18'h00001});
        checkOutput("recover_err", 32'(bus.err), 32'd0);

        // Oversized count, plus the exact-depth boundary header.
        frameQ.delete();
        pushBytes(8'hA5, 8'h01, 8'h20);
        runFrame(1'b1);
        checkOutput("big_cnt_cpu_rst", 32'(bus.cpu_rst), 32'd1);
        doReset();
        applyStimulus(8'hA5); idle(1);
        applyStimulus(8'h00); idle(1);
        applyStimulus(8'h20); idle(1);
        checkOutput("depth_ok", 32'(bus.err), 32'd0);

        // Silence for the full timeout inside a frame.
        doReset();
        applyStimulus(8'hA5); idle(1);
        applyStimulus(8'h01); idle(1);
        applyStimulus(8'h00); idle(1);
        applyStimulus(8'h34);
        idle(TB_TIMEOUT - 1);
        checkOutput("tmo_before", 32'(bus.err), 32'd0);
        idle(1);
        checkOutput("tmo_err", 32'(bus.err), 32'd1);
        checkOutput("tmo_busy", 32'(bus.busy), 32'd0);

        // A byte on the timeout cycle wins.
        doReset();
        obsQ.delete();
        applyStimulus(8'hA5); idle(1);
        applyStimulus(8'h01); idle(1);
        applyStimulus(8'h00); idle(1);
        applyStimulus(8'h34);
        idle(TB_TIMEOUT - 1);
        applyStimulus(8'h12);
        checkOutput("tmo_byte_wins", 32'(bus.err), 32'd0);
        idle(2);
        applyStimulus(8'h00);
        checkOutput("tmo_wr", 32'(bus.mem_wr), 32'd1);
        idle(2);
`ifdef TEXT_LOADER_CHECKSUM_EN
        applyStimulus(8'hB9);
        idle(2);
`endif
        checkOutput("tmo_done", 32'(bus.done), 32'd1);
        checkOutput("tmo_word", 32'(obsQ.size() > 0 ? obsQ[0] : 31'h7FFFFFFF), {1'b0, 13'd0, 18'h01234});

        // Reset in DATA1 drops the frame; trailing bytes must not complete a word.
        doReset();
        obsQ.delete();
        applyStimulus(8'hA5); idle(1);
        applyStimulus(8'h01); idle(1);
        applyStimulus(8'h00); idle(1);
        applyStimulus(8'h01); idle(1);
        doReset();
        checkResetValues();
        applyStimulus(8'h12); idle(1);
        applyStimulus(8'h00); idle(2);
        checkOutput("mid_rst_no_wr", 32'(obsQ.size()), 32'd0);
        checkOutput("mid_rst_busy", 32'(bus.busy), 32'd0);

        for (int n = 0; n < 30; n++) begin
            buildRandomFrame();
            runFrame(1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

endmodule
